// File: rtl/rvv_backend_retire_wb_pkg.sv
// Shared retire types and sizing constants. Optional feature macro: RT_MERGE_EN
// (merge same-index VRF writes instead of stalling the younger uop).
`ifndef RVV_BACKEND_DEFINES
`define RVV_BACKEND_DEFINES
`define NUM_RT_UOP 4
`define VLEN 128
`define VLENB 16
`define REGFILE_INDEX_WIDTH 5
`endif

package rvv_backend_retire_wb_pkg;

  typedef struct packed {
    logic                            w_valid;
    logic [`REGFILE_INDEX_WIDTH-1:0] w_index;
    logic [`VLEN-1:0]                w_data;
    logic [`VLENB-1:0]               w_strobe;
  } ROB2RT_t;

  typedef struct packed {
    logic [`REGFILE_INDEX_WIDTH-1:0] rt_index;
    logic [`VLEN-1:0]                rt_data;
    logic [`VLENB-1:0]               rt_strobe;
  } RT2VRF_t;

  // Expand a byte strobe to a bit mask over the vector register.
  function automatic logic [`VLEN-1:0] byte_mask(input logic [`VLENB-1:0] s);
    logic [`VLEN-1:0] m;
    m = '0;
    for (int b = 0; b < `VLENB; b++) m[b*8 +: 8] = {8{s[b]}};
    return m;
  endfunction

endpackage

// File: rtl/rvv_backend_retire_wb_if.sv
// ROB -> retire handshake bundle; ROB side is master, retire stage is slave.
interface rvv_backend_retire_wb_if;
  import rvv_backend_retire_wb_pkg::*;

  logic    [`NUM_RT_UOP-1:0] rob2rt_valid;
  ROB2RT_t [`NUM_RT_UOP-1:0] rob2rt_data;
  logic    [`NUM_RT_UOP-1:0] rt2rob_ready;

  modport master (output rob2rt_valid, rob2rt_data, input rt2rob_ready);
  modport slave  (input rob2rt_valid, rob2rt_data, output rt2rob_ready);
endinterface

// File: rtl/rvv_backend_retire_merge.sv
// Same-index handling across retire slots: merge (RT_MERGE_EN) or stall the
// first conflicting slot and everything younger.
module rvv_backend_retire_merge
  import rvv_backend_retire_wb_pkg::*;
(
  input  logic    [`NUM_RT_UOP-1:0] pfx,
  input  ROB2RT_t [`NUM_RT_UOP-1:0] uop,
  output logic    [`NUM_RT_UOP-1:0] blk,
  output logic    [`NUM_RT_UOP-1:0] out_vld,
  output RT2VRF_t [`NUM_RT_UOP-1:0] out_data
);
  logic [`NUM_RT_UOP-1:0] wr;
  logic [`NUM_RT_UOP-1:0] acc;

  // An all-zero strobe retires like a non-writing uop.
  always_comb begin
    for (int i = 0; i < `NUM_RT_UOP; i++) wr[i] = uop[i].w_valid & (|uop[i].w_strobe);
  end

`ifdef RT_MERGE_EN
  assign blk = '0;
  assign acc = pfx;

  // Only the youngest same-index writer emits; it folds older bytes in order.
  always_comb begin
    out_vld  = '0;
    out_data = '0;
    for (int j = 0; j < `NUM_RT_UOP; j++) begin
      out_data[j].rt_index = uop[j].w_index;
      out_vld[j] = acc[j] & wr[j];
      for (int k = j + 1; k < `NUM_RT_UOP; k++)
        if (acc[k] && wr[k] && uop[k].w_index == uop[j].w_index) out_vld[j] = 1'b0;
      for (int i = 0; i <= j; i++)
        if (acc[i] && wr[i] && uop[i].w_index == uop[j].w_index) begin
          out_data[j].rt_data = (out_data[j].rt_data & ~byte_mask(uop[i].w_strobe))
                              | (uop[i].w_data & byte_mask(uop[i].w_strobe));
          out_data[j].rt_strobe = out_data[j].rt_strobe | uop[i].w_strobe;
        end
    end
  end
`else
  logic stall;

  // Using pfx for older slots is safe: before the first conflict none are blocked.
  always_comb begin
    blk   = '0;
    stall = 1'b0;
    for (int j = 0; j < `NUM_RT_UOP; j++) begin
      for (int i = 0; i < j; i++)
        if (pfx[i] && wr[i] && wr[j] && uop[i].w_index == uop[j].w_index) stall = 1'b1;
      blk[j] = stall;
    end
  end

  assign acc = pfx & ~blk;

  always_comb begin
    out_vld  = '0;
    out_data = '0;
    for (int j = 0; j < `NUM_RT_UOP; j++) begin
      out_vld[j]            = acc[j] & wr[j];
      out_data[j].rt_index  = uop[j].w_index;
      out_data[j].rt_data   = uop[j].w_data & byte_mask(uop[j].w_strobe);
      out_data[j].rt_strobe = uop[j].w_strobe;
    end
  end
`endif

endmodule

// File: rtl/rvv_backend_retire_wb.sv
// Retire write-back: in-order ready prefix, registered VRF write slots and a
// retired-uop counter. Optional feature macro: RT_MERGE_EN.
module rvv_backend_retire_wb
  import rvv_backend_retire_wb_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  rvv_backend_retire_wb_if.slave       rob2rt,
  output logic    [`NUM_RT_UOP-1:0]    rt2vrf_wr_valid,
  output RT2VRF_t [`NUM_RT_UOP-1:0]    rt2vrf_wr_data,
  output logic    [31:0]               rt_uop_cnt
);
  logic    [`NUM_RT_UOP-1:0] pfx;
  logic    [`NUM_RT_UOP-1:0] blk;
  logic    [`NUM_RT_UOP-1:0] out_vld;
  RT2VRF_t [`NUM_RT_UOP-1:0] out_data;
  logic    [`NUM_RT_UOP-1:0] ready;
  logic                      run;

  always_comb begin
    run = 1'b1;
    for (int i = 0; i < `NUM_RT_UOP; i++) begin
      run    = run & rob2rt.rob2rt_valid[i];
      pfx[i] = run;
    end
  end

  rvv_backend_retire_merge u_merge (
    .pfx      (pfx),
    .uop      (rob2rt.rob2rt_data),
    .blk      (blk),
    .out_vld  (out_vld),
    .out_data (out_data)
  );

  assign ready               = rst_n ? (pfx & ~blk) : '0;
  assign rob2rt.rt2rob_ready = ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rt2vrf_wr_valid <= '0;
      rt2vrf_wr_data  <= '0;
      rt_uop_cnt      <= '0;
    end else begin
      rt2vrf_wr_valid <= out_vld;
      for (int i = 0; i < `NUM_RT_UOP; i++)
        if (out_vld[i]) rt2vrf_wr_data[i] <= out_data[i];
      rt_uop_cnt <= rt_uop_cnt + 32'($countones(ready));
    end
  end

endmodule

// File: tb/tb_rvv_backend_retire_wb.sv
// Randomized + directed bench for rvv_backend_retire_wb against a queue-based model.
`timescale 1ns/1ps
module tb_rvv_backend_retire_wb;
  import rvv_backend_retire_wb_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rvv_backend_retire_wb_if rif();
  logic    [`NUM_RT_UOP-1:0] wr_valid;
  RT2VRF_t [`NUM_RT_UOP-1:0] wr_data;
  logic    [31:0]            uop_cnt;

  rvv_backend_retire_wb dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rob2rt          (rif.slave),
    .rt2vrf_wr_valid (wr_valid),
    .rt2vrf_wr_data  (wr_data),
    .rt_uop_cnt      (uop_cnt)
  );

  int n_chk = 0;
  int n_err = 0;

  logic    [`NUM_RT_UOP-1:0] exp_vld;
  RT2VRF_t [`NUM_RT_UOP-1:0] exp_dat;
  logic    [31:0]            exp_cnt;

  task automatic chk(input string tag, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic writes(input ROB2RT_t u);
    return u.w_valid && (u.w_strobe != '0);
  endfunction

  // Accept in order; without merging, a repeated write index ends the group.
  function automatic logic [`NUM_RT_UOP-1:0] m_ready(input logic rst, input logic [`NUM_RT_UOP-1:0] v,
                                                      input ROB2RT_t [`NUM_RT_UOP-1:0] d);
    logic [31:0] seen;
    logic [`NUM_RT_UOP-1:0] r;
    logic stop;
    seen = '0; r = '0; stop = rst;
    for (int i = 0; i < `NUM_RT_UOP; i++) begin
      if (!v[i]) stop = 1'b1;
`ifndef RT_MERGE_EN
      if (writes(d[i]) && seen[d[i].w_index]) stop = 1'b1;
`endif
      if (!stop) begin
        r[i] = 1'b1;
        if (writes(d[i])) seen[d[i].w_index] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic step(input logic rst, input logic [`NUM_RT_UOP-1:0] v,
                      input ROB2RT_t [`NUM_RT_UOP-1:0] d, output logic [`NUM_RT_UOP-1:0] r);
    logic [`NUM_RT_UOP-1:0] nv;
    RT2VRF_t [`NUM_RT_UOP-1:0] nd;
    logic younger, hit;
    rst_n = ~rst;
    rif.rob2rt_valid = v;
    rif.rob2rt_data  = d;
    r = m_ready(rst, v, d);
    #1;
    chk("ready", 160'(rif.rt2rob_ready), 160'(r));
    // Each output byte comes from the youngest accepted writer of that index.
    nv = '0; nd = '0;
    for (int j = 0; j < `NUM_RT_UOP; j++) begin
      if (r[j] && writes(d[j])) begin
        younger = 1'b0;
        for (int k = j + 1; k < `NUM_RT_UOP; k++)
          if (r[k] && writes(d[k]) && d[k].w_index == d[j].w_index) younger = 1'b1;
        if (!younger) begin
          nv[j] = 1'b1;
          nd[j].rt_index = d[j].w_index;
          for (int b = 0; b < `VLENB; b++) begin
            hit = 1'b0;
            for (int i = j; i >= 0; i--)
              if (!hit && r[i] && writes(d[i]) && d[i].w_index == d[j].w_index && d[i].w_strobe[b]) begin
                hit = 1'b1;
                nd[j].rt_data[b*8 +: 8] = d[i].w_data[b*8 +: 8];
                nd[j].rt_strobe[b] = 1'b1;
              end
          end
        end
      end
    end
    if (rst) begin
      exp_vld = '0; exp_dat = '0; exp_cnt = '0;
    end else begin
      exp_vld = nv;
      for (int j = 0; j < `NUM_RT_UOP; j++) if (nv[j]) exp_dat[j] = nd[j];
      exp_cnt = exp_cnt + 32'($countones(r));
    end
    @(posedge clk); #1;
    chk("wr_valid", 160'(wr_valid), 160'(exp_vld));
    for (int j = 0; j < `NUM_RT_UOP; j++)
      chk($sformatf("wr_data[%0d]", j), 160'(wr_data[j]), 160'(exp_dat[j]));
    chk("uop_cnt", 160'(uop_cnt), 160'(exp_cnt));
  endtask

  function automatic ROB2RT_t mk(input logic wv, input int idx, input logic [7:0] fill,
                                 input logic [15:0] strb);
    ROB2RT_t u;
    u.w_valid = wv;
    u.w_index = 5'(idx);
    u.w_data  = {16{fill}};
    u.w_strobe = strb;
    return u;
  endfunction

  function automatic ROB2RT_t rnd_uop();
    ROB2RT_t u;
    u.w_valid = ($urandom_range(0, 3) != 0);
    u.w_index = 5'($urandom_range(0, 3));
    u.w_data  = {$urandom, $urandom, $urandom, $urandom};
    case ($urandom_range(0, 9))
      0, 1, 2: u.w_strobe = 16'hFFFF;
      3:       u.w_strobe = 16'h00FF;
      4:       u.w_strobe = 16'hFF00;
      9:       u.w_strobe = 16'h0000;
      default: u.w_strobe = 16'($urandom);
    endcase
    return u;
  endfunction

  initial begin
    ROB2RT_t [`NUM_RT_UOP-1:0] d;
    logic [`NUM_RT_UOP-1:0] r, v;
    ROB2RT_t q[$];
    exp_vld = '0; exp_dat = '0; exp_cnt = '0;
    rst_n = 1'b0;
    rif.rob2rt_valid = '0;
    rif.rob2rt_data  = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    d = '0;
    step(1'b1, 4'b0000, d, r);
    // Four independent full writes
    for (int i = 0; i < 4; i++) d[i] = mk(1'b1, i + 1, 8'(8'h10 + i), 16'hFFFF);
    step(1'b0, 4'b1111, d, r);
    // Hole in the valid prefix
    for (int i = 0; i < 4; i++) d[i] = mk(1'b1, i + 8, 8'(8'h20 + i), 16'hFFFF);
    step(1'b0, 4'b1011, d, r);
    d[0] = d[2]; d[1] = d[3]; d[2] = '0; d[3] = '0;
    step(1'b0, 4'b0011, d, r);
    // Same index, complementary strobes
    d = '0;
    d[0] = mk(1'b1, 5, 8'hAA, 16'h00FF);
    d[1] = mk(1'b1, 5, 8'hBB, 16'hFF00);
    step(1'b0, 4'b0011, d, r);
    if (r[1] == 1'b0) begin
      d[0] = d[1]; d[1] = '0;
      step(1'b0, 4'b0001, d, r);
    end
    step(1'b0, 4'b0000, d, r);
    // Non-writing older slot
    d = '0;
    d[0] = mk(1'b0, 7, 8'h11, 16'hFFFF);
    d[1] = mk(1'b1, 7, 8'h22, 16'hFFFF);
    step(1'b0, 4'b0011, d, r);
    // Zero strobe, then three-way same index
    d[0] = mk(1'b1, 3, 8'h33, 16'h0000);
    d[1] = mk(1'b1, 3, 8'h44, 16'h0F0F);
    d[2] = mk(1'b1, 3, 8'h55, 16'h00F0);
    d[3] = mk(1'b1, 3, 8'h66, 16'h8001);
    step(1'b0, 4'b1111, d, r);
    // Reset with everything valid
    for (int i = 0; i < 4; i++) d[i] = mk(1'b1, i, 8'h77, 16'hFFFF);
    step(1'b1, 4'b1111, d, r);

    // Randomized in-order ROB stream with occasional reset
    for (int c = 0; c < 400; c++) begin
      while (q.size() < 8) q.push_back(rnd_uop());
      for (int i = 0; i < 4; i++) begin
        v[i] = ($urandom_range(0, 5) != 0);
        d[i] = q[i];
      end
      step(($urandom_range(0, 49) == 0), v, d, r);
      for (int i = 0; i < $countones(r); i++) void'(q.pop_front());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
